// File: rtl/ddr_burst_sched.sv
// ddr_burst_sched: round-robin write/read DDR burst scheduler, one burst outstanding,
// reads frame-gated by hdmi_vs. Define SCHED_WATCHDOG_EN to add the WAIT-state watchdog.
module ddr_burst_sched #(
  parameter int BURST_LEN   = 16,
  parameter int WFIFO_CNT_W = 10,
  parameter int RFIFO_CNT_W = 10,
  parameter int RFIFO_DEPTH = 512,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   sclk,
  input  logic                   s_rst,
  input  logic                   sched_en,
  input  logic [WFIFO_CNT_W-1:0] wfifo_rd_cnt,
  input  logic [RFIFO_CNT_W-1:0] rfifo_wr_cnt,
  input  logic                   hdmi_vs,
  input  logic                   wr_done,
  input  logic                   rd_done,
  output logic                   wr_trig,
  output logic                   rd_trig,
  output logic                   wr_busy,
  output logic                   rd_busy,
  output logic [15:0]            wr_burst_cnt,
  output logic [15:0]            rd_burst_cnt,
  output logic                   timeout_err
);

  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT} state_t;

  // Read threshold computed one bit wider than the count; negative means never eligible.
  localparam int RD_LIM_I = RFIFO_DEPTH - BURST_LEN;
  localparam logic RD_NEVER = (RD_LIM_I < 0);
  localparam logic [RFIFO_CNT_W:0] RD_LIM =
    RD_NEVER ? '0 :
    (RD_LIM_I >= (2 ** (RFIFO_CNT_W + 1))) ? '1 : (RFIFO_CNT_W + 1)'(RD_LIM_I);
  localparam logic [WFIFO_CNT_W:0] WR_MIN = (WFIFO_CNT_W + 1)'(BURST_LEN);

  state_t state;
  logic   vs_m, vs_s, vs_d;
  logic   last_rd;
  logic   wr_elig, rd_elig, vs_rise;
  logic   timeout_hit;

  assign wr_elig = ({1'b0, wfifo_rd_cnt} >= WR_MIN);
  assign rd_elig = !vs_s && !RD_NEVER && ({1'b0, rfifo_wr_cnt} <= RD_LIM);
  assign vs_rise = vs_s && !vs_d;

`ifdef SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_err;

  // A done or frame abort in the final cycle wins over the timeout.
  assign timeout_hit = (wd_cnt == WD_LAST) &&
                       ((state == WR_WAIT && !wr_done) ||
                        (state == RD_WAIT && !rd_done && !vs_s));
  assign timeout_err = wd_err;

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      if (state == WR_WAIT || state == RD_WAIT) wd_cnt <= wd_cnt + 1'b1;
      else                                      wd_cnt <= '0;
      if (timeout_hit) wd_err <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      vs_m         <= 1'b0;
      vs_s         <= 1'b0;
      vs_d         <= 1'b0;
      state        <= IDLE;
      last_rd      <= 1'b1;
      wr_trig      <= 1'b0;
      rd_trig      <= 1'b0;
      wr_busy      <= 1'b0;
      rd_busy      <= 1'b0;
      wr_burst_cnt <= '0;
      rd_burst_cnt <= '0;
    end else begin
      vs_m    <= hdmi_vs;
      vs_s    <= vs_m;
      vs_d    <= vs_s;
      wr_trig <= 1'b0;
      rd_trig <= 1'b0;
      if (vs_rise) rd_burst_cnt <= '0;
      case (state)
        IDLE: begin
          if (sched_en && (wr_elig || rd_elig)) begin
            if (wr_elig && (!rd_elig || last_rd)) begin
              state   <= WR_ISSUE;
              wr_trig <= 1'b1;
              wr_busy <= 1'b1;
              last_rd <= 1'b0;
            end else begin
              state   <= RD_ISSUE;
              rd_trig <= 1'b1;
              rd_busy <= 1'b1;
              last_rd <= 1'b1;
            end
          end
        end
        WR_ISSUE: state <= WR_WAIT;
        WR_WAIT: begin
          if (wr_done) begin
            state        <= IDLE;
            wr_busy      <= 1'b0;
            wr_burst_cnt <= wr_burst_cnt + 16'd1;
          end else if (timeout_hit) begin
            state   <= IDLE;
            wr_busy <= 1'b0;
          end
        end
        RD_ISSUE: begin
          if (vs_s) begin
            state   <= IDLE;
            rd_busy <= 1'b0;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Master drops the read on vsync, so the abort takes priority over rd_done.
          if (vs_s || timeout_hit) begin
            state   <= IDLE;
            rd_busy <= 1'b0;
          end else if (rd_done) begin
            state        <= IDLE;
            rd_busy      <= 1'b0;
            rd_burst_cnt <= rd_burst_cnt + 16'd1;
          end
        end
        default: begin
          state   <= IDLE;
          wr_busy <= 1'b0;
          rd_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ddr_burst_sched.md
# ddr_burst_sched

Burst scheduler that sits between the write/read FIFOs and the AXI4 burst master in the DDR frame-buffer path. It watches the write-FIFO fill level and read-FIFO free space, and arbitrates round-robin between write and read bursts. It issues single-cycle `wr_trig` / `rd_trig` pulses and holds off further requests until the issued burst completes. Only one burst is ever outstanding. Read scheduling is frame-gated by `hdmi_vs`.

## Interface
Parameters:
- `BURST_LEN`, 16: beats per burst (128-bit words); matches master awlen/arlen+1.
- `WFIFO_CNT_W`, 10: width of the write-FIFO read-count.
- `RFIFO_CNT_W`, 10: width of the read-FIFO write-count.
- `RFIFO_DEPTH`, 512: read-FIFO depth in words.
- `TIMEOUT_CYC`, 4096: watchdog limit in sclk cycles (only with `SCHED_WATCHDOG_EN`).

Ports:
- `sclk` in 1: ui_clk; single clock domain.
- `s_rst` in 1: reset, synchronous, active-high.
- `sched_en` in 1: when 0, no new grant; an in-flight burst still completes.
- `wfifo_rd_cnt` in `WFIFO_CNT_W`: words available in write FIFO.
- `rfifo_wr_cnt` in `RFIFO_CNT_W`: words stored in read FIFO.
- `hdmi_vs` in 1: display vsync; asynchronous, synchronized internally.
- `wr_done` in 1: pulse on write-response handshake (bvalid & bready).
- `rd_done` in 1: pulse on last read beat (rvalid & rready & rlast).
- `wr_trig` out 1: one-cycle write-burst request to master.
- `rd_trig` out 1: one-cycle read-burst request to master.
- `wr_busy` out 1: write burst outstanding.
- `rd_busy` out 1: read burst outstanding.
- `wr_burst_cnt` out 16: completed write bursts, free-running.
- `rd_burst_cnt` out 16: completed read bursts in current frame.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT.
- `wr_elig` = `wfifo_rd_cnt` >= `BURST_LEN`.
- `rd_elig` = `vs_s` == 0 and `rfifo_wr_cnt` <= `RFIFO_DEPTH` - `BURST_LEN`.
  - Compare at `RFIFO_CNT_W`+1 bits; no underflow.
- `vs_s` is `hdmi_vs` after a 2-FF synchronizer.
- IDLE with `sched_en`=1:
  - Only `wr_elig` → WR_ISSUE.
  - Only `rd_elig` → RD_ISSUE.
  - Both → grant the side opposite `last_grant`.
  - `last_grant` updates on every grant; reset value = read, so the first tie goes to write.
- WR_ISSUE / RD_ISSUE: last exactly one cycle, then go to the matching WAIT state.
- WR_WAIT → IDLE on `wr_done`; `wr_burst_cnt` +1, wrapping 65535→0.
- RD_WAIT → IDLE on `rd_done`; `rd_burst_cnt` +1, wrapping.
- Frame abort:
  - Any cycle with `vs_s`=1 in RD_ISSUE or RD_WAIT → IDLE, because the master aborts reads on vsync. No count increment.
  - `rd_burst_cnt` clears on the rising edge of `vs_s`.
- Done pulses received outside the matching WAIT state are ignored.
- `sched_en` deasserting does not abort an ISSUE or WAIT in progress.

## Timing
- `wr_trig` = (state==WR_ISSUE); `rd_trig` = (state==RD_ISSUE). Both are registered state decodes.
- Trigger latency: eligibility true in IDLE at cycle t → trig high at cycle t+1, for exactly one cycle.
- `wr_busy` high in WR_ISSUE and WR_WAIT; `rd_busy` likewise for the read states.
- Done at cycle t in WAIT → IDLE at t+1 → earliest next trig at t+2.
  - Back-to-back burst spacing is therefore at least 2 idle cycles plus the master latency.
- `hdmi_vs` → `vs_s` latency: 2 cycles. The abort takes effect the cycle after `vs_s` rises.
- Reset (`s_rst`=1 at a sclk edge, any state):
  - State → IDLE; all outputs 0; counters 0; sync FFs 0; `last_grant` = read.
  - Applies mid-burst too; the master is reset in the same domain.

## Configuration
- `SCHED_WATCHDOG_EN` defined:
  - A cycle counter runs in WR_WAIT/RD_WAIT and clears on state entry.
  - On reaching `TIMEOUT_CYC` cycles without done: → IDLE, `timeout_err` set (sticky until `s_rst`), no count increment.
- Not defined: no counter; WAIT states wait indefinitely; `timeout_err` tied 0.

## Test plan
- Reset, `wfifo_rd_cnt`=16, `rd_elig` false → `wr_trig` one cycle after release; `wr_done` 20 cycles later → `wr_burst_cnt`=1, `wr_busy` falls next cycle.
- Both sides eligible continuously, done returned 5 cycles after each trig → grants alternate W,R,W,R; first grant is write.
- `wfifo_rd_cnt`=15 → no `wr_trig`. `rfifo_wr_cnt`=497 with DEPTH 512 → no `rd_trig`; 496 → `rd_trig`.
- `hdmi_vs` pulsed during RD_WAIT → IDLE 3 cycles after the edge, `rd_burst_cnt`=0, no `rd_trig` while vs high, resumes after vs falls.
- `s_rst` asserted in WR_WAIT → IDLE, all outputs 0 next cycle; a stray `wr_done` afterwards → `wr_burst_cnt` stays 0.
- With `SCHED_WATCHDOG_EN`, TIMEOUT_CYC=64, no done after trig → IDLE after 64 WAIT cycles, `timeout_err`=1 persisting; without the macro → stays in WAIT, `timeout_err`=0.
